// File: rtl/spi_apb_master_bridge_pkg.sv
// Shared types and frame-geometry helpers for the SPI-to-APB master bridge.
package spi_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_RDATA,
    ST_STAT,
    ST_DONE
  } state_t;

  localparam logic STATUS_OK   = 1'b1;
  localparam logic STATUS_FAIL = 1'b0;

  function automatic int sel_width(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

  function automatic int hdr_len(input int num_slaves, input int addr_width);
    return 1 + sel_width(num_slaves) + addr_width;
  endfunction

  function automatic int frame_len(input int num_slaves, input int addr_width,
                                   input int data_width, input int turn_bits);
    return hdr_len(num_slaves, addr_width) + data_width + turn_bits + 1;
  endfunction

  // First turnaround bit, where the APB SETUP phase starts.
  function automatic int t0_bit(input logic wr, input int h, input int data_width);
    return wr ? h + data_width : h;
  endfunction

endpackage

// File: rtl/spi_apb_master_bridge_if.sv
// SPI pins and APB master bus of the bridge, grouped with bridge/environment views.
interface spi_apb_master_bridge_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_SLAVES = 2
);
  logic                             ss;
  logic                             mosi;
  logic                             miso;
  logic                             miso_oe;
  logic                             pclk;
  logic                             presetn;
  logic [NUM_SLAVES-1:0]            psel;
  logic                             penable;
  logic                             pwrite;
  logic [ADDR_WIDTH-1:0]            paddr;
  logic [DATA_WIDTH-1:0]            pwdata;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLAVES-1:0]            pready;
  logic [NUM_SLAVES-1:0]            pslverr;

  modport master (
    input  ss, mosi, prdata, pready, pslverr,
    output miso, miso_oe, pclk, presetn, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output ss, mosi, prdata, pready, pslverr,
    input  miso, miso_oe, pclk, presetn, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/spi_apb_master_bridge_shifter.sv
// Frame bit counter, mosi shift register and negedge miso data/status path.
module spi_apb_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int HDR_LEN    = 5,
  parameter int FRAME_LEN  = 18,
  parameter int TURN_BITS  = 4,
  localparam int CW        = $clog2(FRAME_LEN + 1),
  localparam int SR_LEN    = HDR_LEN + DATA_WIDTH
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  mosi,
  input  logic                  rd_phase,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  status,
  output logic [CW-1:0]         cnt,
  output logic [SR_LEN-1:0]     shreg,
  output logic                  miso
);

  logic [DATA_WIDTH-1:0] osr;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      if (cnt != CW'(FRAME_LEN)) cnt <= cnt + 1'b1;
      if (cnt < CW'(SR_LEN)) shreg <= {shreg[SR_LEN-2:0], mosi};
    end
  end

  // cnt here is already the index of the bit the master samples next.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      miso <= 1'b0;
      osr  <= '0;
    end else if (cnt == CW'(FRAME_LEN - 1)) begin
      miso <= status;
    end else if (rd_phase && cnt == CW'(HDR_LEN + TURN_BITS)) begin
      miso <= rdata[DATA_WIDTH-1];
      osr  <= rdata << 1;
    end else if (rd_phase && cnt > CW'(HDR_LEN + TURN_BITS) && cnt < CW'(FRAME_LEN - 1)) begin
      miso <= osr[DATA_WIDTH-1];
      osr  <= osr << 1;
    end else begin
      miso <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_apb_master_bridge.sv
// SPI mode-0 slave frame decoder driving one APB read or write per frame.
//
// state     | meaning
// ST_IDLE   | frame not started (ss high or before bit 0)
// ST_HDR    | shifting W, SEL, ADDR
// ST_WDATA  | shifting write data
// ST_SETUP  | psel high, penable low
// ST_ACCESS | psel and penable high, polling pready
// ST_RDATA  | read data shifting out on miso
// ST_STAT   | waiting for the status bit
// ST_DONE   | frame complete, extra bits ignored
module spi_apb_master_bridge
  import spi_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_SLAVES = 2,
  parameter int TURN_BITS  = 4
) (
  input logic                     sclk,
  input logic                     resetn,
  spi_apb_master_bridge_if.master bus
);

  localparam int SW     = sel_width(NUM_SLAVES);
  localparam int H      = hdr_len(NUM_SLAVES, ADDR_WIDTH);
  localparam int N      = frame_len(NUM_SLAVES, ADDR_WIDTH, DATA_WIDTH, TURN_BITS);
  localparam int CW     = $clog2(N + 1);
  localparam int SR_LEN = H + DATA_WIDTH;
  localparam int T0_RD  = t0_bit(1'b0, H, DATA_WIDTH);
  localparam int T0_WR  = t0_bit(1'b1, H, DATA_WIDTH);

  logic                  frame_rst_n;
  logic [CW-1:0]         cnt;
  logic [SR_LEN-1:0]     shreg;
  logic                  miso_d;
  state_t                state;
  logic [NUM_SLAVES-1:0] psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  status_q;
  logic                  rdy_m;
  logic                  err_m;
  logic [DATA_WIDTH-1:0] rdata_m;
  logic [CW-1:0]         t_last;

  // ss high is an asynchronous frame reset on top of the global reset.
  assign frame_rst_n = resetn & ~bus.ss;
  assign t_last      = pwrite_q ? CW'(T0_WR + TURN_BITS - 1) : CW'(T0_RD + TURN_BITS - 1);

  function automatic logic [NUM_SLAVES-1:0] sel_onehot(input logic [SW-1:0] s);
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(s) == i) sel_onehot[i] = 1'b1;
  endfunction

  spi_apb_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .HDR_LEN    (H),
    .FRAME_LEN  (N),
    .TURN_BITS  (TURN_BITS)
  ) u_shifter (
    .sclk     (sclk),
    .rst_n    (frame_rst_n),
    .mosi     (bus.mosi),
    .rd_phase (state == ST_RDATA),
    .rdata    (rdata_q),
    .status   (status_q),
    .cnt      (cnt),
    .shreg    (shreg),
    .miso     (miso_d)
  );

  // Out-of-range SEL matches no slave, so pready never arrives and the access times out.
  always_comb begin
    rdy_m   = 1'b0;
    err_m   = 1'b0;
    rdata_m = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(sel_q) == i) begin
        rdy_m   = bus.pready[i];
        err_m   = bus.pslverr[i];
        rdata_m = bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      sel_q    <= '0;
    end else if (state == ST_HDR && cnt == CW'(T0_RD) && !shreg[H-1]) begin
      pwrite_q <= 1'b0;
      paddr_q  <= shreg[ADDR_WIDTH-1:0];
      sel_q    <= shreg[ADDR_WIDTH +: SW];
    end else if (state == ST_WDATA && cnt == CW'(T0_WR)) begin
      pwrite_q <= shreg[SR_LEN-1];
      pwdata_q <= shreg[DATA_WIDTH-1:0];
      paddr_q  <= shreg[DATA_WIDTH +: ADDR_WIDTH];
      sel_q    <= shreg[DATA_WIDTH+ADDR_WIDTH +: SW];
    end
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state     <= ST_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      status_q  <= STATUS_FAIL;
    end else begin
      case (state)
        ST_IDLE: state <= ST_HDR;
        ST_HDR: begin
          if (cnt == CW'(T0_RD)) begin
            if (shreg[H-1]) begin
              state <= ST_WDATA;
            end else begin
              state  <= ST_SETUP;
              psel_q <= sel_onehot(shreg[ADDR_WIDTH +: SW]);
            end
          end
        end
        ST_WDATA: begin
          if (cnt == CW'(T0_WR)) begin
            state  <= ST_SETUP;
            psel_q <= sel_onehot(shreg[DATA_WIDTH+ADDR_WIDTH +: SW]);
          end
        end
        ST_SETUP: begin
          state     <= ST_ACCESS;
          penable_q <= |psel_q;
        end
        ST_ACCESS: begin
          if (rdy_m || cnt == t_last) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            status_q  <= (rdy_m && !err_m) ? STATUS_OK : STATUS_FAIL;
            rdata_q   <= rdy_m ? rdata_m : '0;
            state     <= pwrite_q ? ST_STAT : ST_RDATA;
          end
        end
        ST_RDATA: if (cnt == CW'(N - 2)) state <= ST_STAT;
        ST_STAT:  if (cnt == CW'(N - 1)) state <= ST_DONE;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miso    = miso_d;
  assign bus.miso_oe = ~bus.ss;
  assign bus.pclk    = sclk;
  assign bus.presetn = resetn;
  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;

endmodule

// File: tb/tb_spi_apb_master_bridge.sv
// Directed bench for the SPI-to-APB bridge: default 2-slave instance plus a 3-slave instance.
module tb_spi_apb_master_bridge;

  logic sclk;
  logic resetn;
  int   checks;
  int   failures;

  spi_apb_master_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_SLAVES(2)) bus2 ();
  spi_apb_master_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_SLAVES(3)) bus3 ();

  spi_apb_master_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_SLAVES(2), .TURN_BITS(4))
    dut (.sclk(sclk), .resetn(resetn), .bus(bus2));

  spi_apb_master_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_SLAVES(3), .TURN_BITS(4))
    dut3 (.sclk(sclk), .resetn(resetn), .bus(bus3));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic [1:0] psel_log [0:21];
  logic       pen_log  [0:21];
  logic       miso_log [0:21];

  localparam logic [17:0] WR_FRAME = {5'b11101, 8'hA5, 5'b00000};
  localparam logic [17:0] RD_FRAME = {5'b00011, 13'b0};

  // Drives one frame on the 2-slave bus, logging outputs #1 after each posedge.
  // stop_at >= 0 leaves ss low right after sampling that bit.
  task automatic run_frame(input logic [17:0] fr, input int nbits, input int sel,
                           input int rdy_bit, input logic err, input logic [7:0] rd,
                           input int stop_at);
    for (int k = 0; k < 22; k++) begin
      psel_log[k] = 2'b00; pen_log[k] = 1'b0; miso_log[k] = 1'b0;
    end
    bus2.prdata = '0;
    bus2.prdata[sel*8 +: 8] = rd;
    @(negedge sclk);
    bus2.ss = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      bus2.mosi    = (k < 18) ? fr[17-k] : 1'b1;
      bus2.pready  = (rdy_bit >= 0 && k >= rdy_bit) ? (2'b01 << sel) : 2'b00;
      bus2.pslverr = err ? bus2.pready : 2'b00;
      @(posedge sclk);
      #1;
      psel_log[k] = bus2.psel;
      pen_log[k]  = bus2.penable;
      miso_log[k] = bus2.miso;
      if (k == stop_at) return;
      @(negedge sclk);
    end
    bus2.ss = 1'b1; bus2.mosi = 1'b0; bus2.pready = 2'b00; bus2.pslverr = 2'b00;
    @(negedge sclk);
  endtask

  function automatic logic [7:0] rd_bits(input int first);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = miso_log[first+i];
    return v;
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    checks++;
    if (bus2.psel !== 2'b00 || bus2.penable !== 1'b0) begin
      failures++; $display("FAIL reset_apb psel=%b penable=%b expected 00/0", bus2.psel, bus2.penable);
    end
    checks++;
    if ({bus2.pwrite, bus2.paddr, bus2.pwdata} !== 12'h000) begin
      failures++; $display("FAIL reset_regs got=%h expected 000", {bus2.pwrite, bus2.paddr, bus2.pwdata});
    end
    checks++;
    if (bus2.miso !== 1'b0 || bus2.miso_oe !== 1'b0) begin
      failures++; $display("FAIL reset_miso miso=%b oe=%b expected 0/0", bus2.miso, bus2.miso_oe);
    end
    @(negedge sclk);
    resetn = 1'b1;
    @(negedge sclk);
  endtask

  task automatic test_write;
    int pen_cnt;
    run_frame(WR_FRAME, 18, 1, 15, 1'b0, 8'h00, -1);
    pen_cnt = 0;
    for (int k = 0; k < 18; k++) pen_cnt += int'(pen_log[k]);
    checks++;
    if (psel_log[12] !== 2'b00 || psel_log[13] !== 2'b10 || pen_log[13] !== 1'b0) begin
      failures++; $display("FAIL write_setup psel12=%b psel13=%b pen13=%b expected 00/10/0",
                           psel_log[12], psel_log[13], pen_log[13]);
    end
    checks++;
    if (psel_log[14] !== 2'b10 || pen_log[14] !== 1'b1) begin
      failures++; $display("FAIL write_access psel=%b pen=%b expected 10/1", psel_log[14], pen_log[14]);
    end
    checks++;
    if (psel_log[15] !== 2'b00 || pen_log[15] !== 1'b0 || pen_cnt != 1) begin
      failures++; $display("FAIL write_end psel15=%b pen15=%b pen_cycles=%0d expected 00/0/1",
                           psel_log[15], pen_log[15], pen_cnt);
    end
    checks++;
    if (bus2.pwrite !== 1'b1 || bus2.paddr !== 3'd5 || bus2.pwdata !== 8'hA5) begin
      failures++; $display("FAIL write_regs pwrite=%b paddr=%0d pwdata=%h expected 1/5/a5",
                           bus2.pwrite, bus2.paddr, bus2.pwdata);
    end
    checks++;
    if (rd_bits(9) !== 8'h00 || miso_log[17] !== 1'b1) begin
      failures++; $display("FAIL write_miso data=%h status=%b expected 00/1", rd_bits(9), miso_log[17]);
    end
  endtask

  task automatic test_read(input int nbits);
    run_frame(RD_FRAME, nbits, 0, 7, 1'b0, 8'h3C, -1);
    checks++;
    if (psel_log[5] !== 2'b01 || pen_log[6] !== 1'b1 || psel_log[7] !== 2'b00) begin
      failures++; $display("FAIL read_apb psel5=%b pen6=%b psel7=%b expected 01/1/00",
                           psel_log[5], pen_log[6], psel_log[7]);
    end
    checks++;
    if (bus2.pwrite !== 1'b0 || bus2.paddr !== 3'd3) begin
      failures++; $display("FAIL read_regs pwrite=%b paddr=%0d expected 0/3", bus2.pwrite, bus2.paddr);
    end
    checks++;
    if (rd_bits(9) !== 8'h3C || miso_log[17] !== 1'b1 || miso_log[8] !== 1'b0) begin
      failures++; $display("FAIL read_miso data=%h status=%b bit8=%b expected 3c/1/0",
                           rd_bits(9), miso_log[17], miso_log[8]);
    end
    if (nbits > 18) begin
      checks++;
      if (miso_log[18] !== 1'b0 || miso_log[19] !== 1'b0 || psel_log[18] !== 2'b00 || psel_log[19] !== 2'b00) begin
        failures++; $display("FAIL read_extra miso=%b%b psel=%b/%b expected 00 and 00/00",
                             miso_log[18], miso_log[19], psel_log[18], psel_log[19]);
      end
    end
  endtask

  task automatic test_timeout;
    run_frame(RD_FRAME, 18, 0, -1, 1'b0, 8'hFF, -1);
    checks++;
    if (psel_log[7] !== 2'b01 || pen_log[7] !== 1'b1 || psel_log[8] !== 2'b00 || pen_log[8] !== 1'b0) begin
      failures++; $display("FAIL timeout_apb psel7=%b pen7=%b psel8=%b pen8=%b expected 01/1/00/0",
                           psel_log[7], pen_log[7], psel_log[8], pen_log[8]);
    end
    checks++;
    if (rd_bits(9) !== 8'h00 || miso_log[17] !== 1'b0) begin
      failures++; $display("FAIL timeout_miso data=%h status=%b expected 00/0", rd_bits(9), miso_log[17]);
    end
  endtask

  task automatic test_error;
    run_frame(RD_FRAME, 18, 0, 7, 1'b1, 8'h81, -1);
    checks++;
    if (rd_bits(9) !== 8'h81 || miso_log[17] !== 1'b0) begin
      failures++; $display("FAIL error_miso data=%h status=%b expected 81/0", rd_bits(9), miso_log[17]);
    end
  endtask

  task automatic test_invalid_sel;
    logic [18:0] fr;
    logic [2:0]  psel_or;
    logic        pen_or;
    logic [7:0]  data;
    logic        stat;
    fr = {1'b0, 2'b11, 3'b010, 13'b0};
    psel_or = 3'b000; pen_or = 1'b0; data = 8'h00; stat = 1'b0;
    bus3.prdata = '1; bus3.pready = 3'b111; bus3.pslverr = 3'b000;
    @(negedge sclk);
    bus3.ss = 1'b0;
    for (int k = 0; k < 19; k++) begin
      bus3.mosi = fr[18-k];
      @(posedge sclk);
      #1;
      psel_or = psel_or | bus3.psel;
      pen_or  = pen_or | bus3.penable;
      if (k >= 10 && k <= 17) data[17-k] = bus3.miso;
      if (k == 18) stat = bus3.miso;
      @(negedge sclk);
    end
    bus3.ss = 1'b1; bus3.pready = 3'b000;
    checks++;
    if (psel_or !== 3'b000 || pen_or !== 1'b0) begin
      failures++; $display("FAIL badsel_apb psel_seen=%b pen_seen=%b expected 000/0", psel_or, pen_or);
    end
    checks++;
    if (data !== 8'h00 || stat !== 1'b0) begin
      failures++; $display("FAIL badsel_miso data=%h status=%b expected 00/0", data, stat);
    end
  endtask

  task automatic test_abort;
    run_frame(WR_FRAME, 18, 1, 15, 1'b0, 8'h00, 13);
    checks++;
    if (bus2.psel !== 2'b10 || bus2.penable !== 1'b0) begin
      failures++; $display("FAIL abort_pre psel=%b pen=%b expected 10/0", bus2.psel, bus2.penable);
    end
    #2;
    bus2.ss = 1'b1;
    #1;
    checks++;
    if (bus2.psel !== 2'b00) begin
      failures++; $display("FAIL abort_async psel=%b expected 00", bus2.psel);
    end
    repeat (2) @(posedge sclk);
    #1;
    checks++;
    if (bus2.penable !== 1'b0 || bus2.miso !== 1'b0) begin
      failures++; $display("FAIL abort_after pen=%b miso=%b expected 0/0", bus2.penable, bus2.miso);
    end
    bus2.pready = 2'b00; bus2.mosi = 1'b0;
    @(negedge sclk);
  endtask

  task automatic test_reset_mid_access;
    run_frame(RD_FRAME, 18, 0, -1, 1'b0, 8'h55, 6);
    checks++;
    if (bus2.penable !== 1'b1 || bus2.psel !== 2'b01) begin
      failures++; $display("FAIL rstmid_pre psel=%b pen=%b expected 01/1", bus2.psel, bus2.penable);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (bus2.psel !== 2'b00 || bus2.penable !== 1'b0 || bus2.miso !== 1'b0 ||
        {bus2.pwrite, bus2.paddr, bus2.pwdata} !== 12'h000) begin
      failures++; $display("FAIL rstmid_out psel=%b pen=%b miso=%b regs=%h expected 00/0/0/000",
                           bus2.psel, bus2.penable, bus2.miso, {bus2.pwrite, bus2.paddr, bus2.pwdata});
    end
    bus2.ss = 1'b1; bus2.pready = 2'b00; bus2.mosi = 1'b0;
    @(negedge sclk);
    resetn = 1'b1;
    @(negedge sclk);
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    bus2.ss = 1'b1; bus2.mosi = 1'b0; bus2.prdata = '0; bus2.pready = '0; bus2.pslverr = '0;
    bus3.ss = 1'b1; bus3.mosi = 1'b0; bus3.prdata = '0; bus3.pready = '0; bus3.pslverr = '0;
    test_reset;
    test_write;
    test_read(18);
    test_timeout;
    test_error;
    test_invalid_sel;
    test_abort;
    test_read(20);
    test_reset_mid_access;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
